// File: rtl/pio_out_arbiter.sv
// Round-robin arbiter and write sequencer sharing one 8-bit PIO output register between two byte producers.
// Define PIO_ARB_READBACK_EN to add a readback check of every write (READ state, sticky rb_error).
module pio_out_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  output logic        req1_ready,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  output logic        busy,
  output logic        last_grant,
  output logic [15:0] write_count,
  output logic        rb_error
);

  // state | meaning
  // IDLE  | offer ready to the round-robin winner; a transfer latches the byte
  // WRITE | one-cycle write strobe of the latched byte to address 0
  // READ  | one-cycle readback compare (readback build only)
  // HOLD  | out_port kept stable for HOLD_CYCLES cycles before the next grant
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LOAD = 8'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);
  localparam state_t     AFTER_IO  = (HOLD_CYCLES == 0) ? S_IDLE : S_HOLD;

  state_t     state, state_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic [7:0] data_q;
  logic       grant0, grant1;
  logic       xfer;

  // Contention goes to the requester that was not granted last.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
  assign xfer   = (state == S_IDLE) && (grant0 || grant1);

  assign pio_address   = 2'b00;
  assign pio_writedata = {24'b0, data_q};

  always_comb begin
    state_nxt      = state;
    hold_cnt_nxt   = hold_cnt;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    case (state)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
`ifdef PIO_ARB_READBACK_EN
        state_nxt      = S_READ;
`else
        state_nxt      = AFTER_IO;
        hold_cnt_nxt   = HOLD_LOAD;
`endif
      end
`ifdef PIO_ARB_READBACK_EN
      S_READ: begin
        pio_chipselect = 1'b1;
        state_nxt      = AFTER_IO;
        hold_cnt_nxt   = HOLD_LOAD;
      end
`endif
      S_HOLD: begin
        if (hold_cnt == 8'd0) state_nxt = S_IDLE;
        else                  hold_cnt_nxt = hold_cnt - 8'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      hold_cnt    <= 8'd0;
      busy        <= 1'b0;
      last_grant  <= 1'b1;
      data_q      <= 8'd0;
      write_count <= 16'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      busy     <= (state_nxt != S_IDLE);
      if (xfer) begin
        data_q     <= grant0 ? req0_data : req1_data;
        last_grant <= grant1;
      end
      if (state == S_WRITE) write_count <= write_count + 16'd1;
    end
  end

`ifdef PIO_ARB_READBACK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      rb_error <= 1'b0;
    else if ((state == S_READ) && (pio_readdata[7:0] != data_q))
      rb_error <= 1'b1;
  end
`else
  assign rb_error = 1'b0;
`endif

  // Upper readdata bits never matter; without readback none of it does.
  logic unused_readdata;
  assign unused_readdata = ^pio_readdata;

endmodule

// File: tb/tb_pio_out_arbiter.sv
// Bench for pio_out_arbiter: two instances (HOLD_CYCLES 4 and 0), a PIO slave model and a transfer-level reference model.
`timescale 1ns/1ps
module tb_pio_out_arbiter;
`ifdef PIO_ARB_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int HOLD_A = 4;
  localparam int HOLD_B = 0;
  localparam int COST_A = 1 + RB + HOLD_A;
  localparam int COST_B = 1 + RB + HOLD_B;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       v0 = '0, v1 = '0;
  logic [1:0][7:0]  d0 = '0, d1 = '0;
  logic [1:0]       r0, r1, cs, wn, busy, lg, rbe;
  logic [1:0][1:0]  addr;
  logic [1:0][31:0] wd, rd;
  logic [1:0][15:0] wc;

  pio_out_arbiter #(.HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(v0[0]), .req0_data(d0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_data(d1[0]), .req1_ready(r1[0]),
    .pio_address(addr[0]), .pio_chipselect(cs[0]), .pio_write_n(wn[0]),
    .pio_writedata(wd[0]), .pio_readdata(rd[0]),
    .busy(busy[0]), .last_grant(lg[0]), .write_count(wc[0]), .rb_error(rbe[0]));

  pio_out_arbiter #(.HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(v0[1]), .req0_data(d0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_data(d1[1]), .req1_ready(r1[1]),
    .pio_address(addr[1]), .pio_chipselect(cs[1]), .pio_write_n(wn[1]),
    .pio_writedata(wd[1]), .pio_readdata(rd[1]),
    .busy(busy[1]), .last_grant(lg[1]), .write_count(wc[1]), .rb_error(rbe[1]));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // PIO slave: register written on the strobe, readback optionally corrupted in bit 0.
  logic [1:0][7:0] sreg = '0;
  int swn [2] = '{0, 0};
  int corrupt_at = -1;
  always @(posedge clk) begin
    if (cs[0] && !wn[0]) begin sreg[0] <= wd[0][7:0]; swn[0] <= swn[0] + 1; end
    if (cs[1] && !wn[1]) begin sreg[1] <= wd[1][7:0]; swn[1] <= swn[1] + 1; end
  end
  assign rd[0] = {24'b0, sreg[0] ^ {7'b0, (swn[0] == corrupt_at)}};
  assign rd[1] = {24'b0, sreg[1]};

  // Reference model: each transfer occupies COST busy cycles after the accept;
  // phase 1 is the write, phase 2 the readback when enabled, the rest is hold.
  int         ph    [2] = '{0, 0};
  logic       m_lg  [2] = '{1'b1, 1'b1};
  logic [15:0] m_cnt[2] = '{16'd0, 16'd0};
  logic [7:0] m_dat [2] = '{8'd0, 8'd0};
  logic       m_rbe [2] = '{1'b0, 1'b0};

  function automatic int cost_of(input int i);
    return (i == 0) ? COST_A : COST_B;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        ph[i] = 0; m_lg[i] = 1'b1; m_cnt[i] = 16'd0; m_dat[i] = 8'd0; m_rbe[i] = 1'b0;
      end else if (ph[i] != 0) begin
        if (ph[i] == 1) m_cnt[i] = m_cnt[i] + 16'd1;
        if (RB == 1 && ph[i] == 2 && rd[i][7:0] != m_dat[i]) m_rbe[i] = 1'b1;
        ph[i] = (ph[i] == cost_of(i)) ? 0 : ph[i] + 1;
      end else if (v0[i] && (!v1[i] || m_lg[i])) begin
        m_dat[i] = d0[i]; m_lg[i] = 1'b0; ph[i] = 1;
      end else if (v1[i]) begin
        m_dat[i] = d1[i]; m_lg[i] = 1'b1; ph[i] = 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin : cmp
      logic e_r0, e_r1, e_cs, e_wn, e_busy;
      e_busy = (ph[i] != 0);
      e_r0   = !e_busy && v0[i] && (!v1[i] || m_lg[i]);
      e_r1   = !e_busy && v1[i] && (!v0[i] || !m_lg[i]);
      e_cs   = (ph[i] == 1) || (RB == 1 && ph[i] == 2);
      e_wn   = (ph[i] != 1);
      check($sformatf("ctl%0d", i),
            {55'd0, r0[i], r1[i], cs[i], wn[i], busy[i], lg[i], rbe[i], addr[i]},
            {55'd0, e_r0, e_r1, e_cs, e_wn, e_busy, m_lg[i], m_rbe[i], 2'b00});
      check($sformatf("wdata%0d", i), {32'd0, wd[i]}, {32'd0, 24'd0, m_dat[i]});
      check($sformatf("count%0d", i), {48'd0, wc[i]}, {48'd0, m_cnt[i]});
    end
  end

  // Activity logs for the directed checks.
  logic [7:0] wr_a[$], wr_b[$];
  int         wcyc_b[$], acc_a[$];
  logic       accg_a[$];
  always @(negedge clk) begin
    if (cs[0] && !wn[0]) wr_a.push_back(wd[0][7:0]);
    if (cs[1] && !wn[1]) begin wr_b.push_back(wd[1][7:0]); wcyc_b.push_back(cyc); end
    if (r0[0] || r1[0]) begin acc_a.push_back(cyc); accg_a.push_back(r1[0]); end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int i, input bit which, input logic [7:0] b);
    int n = 0;
    if (which) begin v1[i] = 1'b1; d1[i] = b; end
    else       begin v0[i] = 1'b1; d0[i] = b; end
    @(negedge clk);
    while (!(which ? r1[i] : r0[i]) && n < 50) begin @(negedge clk); n++; end
    if (!(which ? r1[i] : r0[i])) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout inst=%0d actual=no_ready required=ready", i);
    end
    @(posedge clk); #1;
    if (which) v1[i] = 1'b0; else v0[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    @(negedge clk);
    while (busy[i] && n < 100) begin @(negedge clk); n++; end
    if (busy[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout inst=%0d actual=busy required=idle", i);
    end
    @(posedge clk); #1;
  endtask

  logic [7:0] exp_c [4] = '{8'h11, 8'h22, 8'h11, 8'h22};

  initial begin
    int n;
    repeat (3) tick();
    check("reset_wd", {32'd0, wd[0]}, 64'd0);
    check("reset_state", {58'd0, busy[0], lg[0], cs[0], wn[0], wc[0] == 16'd0, rbe[0]}, {58'd0, 6'b010110});
    reset_n = 1'b1;
    tick();

    // Single byte from requester 0.
    v0[0] = 1'b1; d0[0] = 8'hA5;
    @(negedge clk); check("t1_ready", {63'd0, r0[0]}, 64'd1);
    tick(); v0[0] = 1'b0;
    @(negedge clk); check("t1_write", {30'd0, cs[0], wn[0], wd[0]}, {30'd0, 2'b10, 32'h000000A5});
    tick();
    @(negedge clk);
    check("t1_count", {48'd0, wc[0]}, 64'd1);
    check("t1_outport", {56'd0, sreg[0]}, 64'hA5);
    repeat (3 + RB) tick();
    @(negedge clk); check("t1_busy_hi", {63'd0, busy[0]}, 64'd1);
    tick();
    @(negedge clk); check("t1_busy_lo", {63'd0, busy[0]}, 64'd0);
    tick();

    // Reset pulse in the middle of HOLD.
    send(0, 1'b0, 8'h5A);
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("rst_async", {26'd0, busy[0], lg[0], cs[0], wn[0], wc[0], wd[0]},
          {26'd0, 4'b0101, 16'd0, 32'd0});
    @(negedge clk); @(posedge clk); #3 reset_n = 1'b1;
    tick();

    // Continuous contention: strict alternation starting with requester 0.
    wr_a.delete(); acc_a.delete(); accg_a.delete();
    v0[0] = 1'b1; d0[0] = 8'h11; v1[0] = 1'b1; d1[0] = 8'h22;
    n = 0;
    while (acc_a.size() < 4 && n < 200) begin tick(); n++; end
    v0[0] = 1'b0; v1[0] = 1'b0;
    check("rr_accepts", 64'(acc_a.size()), 64'd4);
    wait_idle(0);
    check("rr_writes", 64'(wr_a.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_byte%0d", k), {56'd0, wr_a[k]}, {56'd0, exp_c[k]});
      check($sformatf("rr_grant%0d", k), {63'd0, accg_a[k]}, 64'(k % 2));
    end
    for (int k = 0; k < 3; k++)
      check($sformatf("rr_space%0d", k), 64'(acc_a[k+1] - acc_a[k]), 64'(2 + RB + HOLD_A));

    // HOLD_CYCLES=0: requester 1 streams 0x00..0x0F.
    wr_b.delete(); wcyc_b.delete();
    for (int k = 0; k < 16; k++) begin
      v1[1] = 1'b1; d1[1] = 8'(k);
      n = 0;
      @(negedge clk);
      while (!r1[1] && n < 20) begin @(negedge clk); n++; end
      if (!r1[1]) begin n_cmp++; n_bad++; $display("FAIL stream_timeout actual=no_ready required=ready"); end
      tick();
    end
    v1[1] = 1'b0;
    wait_idle(1);
    check("stream_writes", 64'(wr_b.size()), 64'd16);
    for (int k = 0; k < 16; k++) check($sformatf("stream_byte%0d", k), {56'd0, wr_b[k]}, 64'(k));
    for (int k = 0; k < 15; k++) check($sformatf("stream_space%0d", k), 64'(wcyc_b[k+1] - wcyc_b[k]), 64'(2 + RB));
    check("stream_lg", {63'd0, lg[1]}, 64'd1);

    // Readback corruption on the third write; flag is sticky until reset.
    corrupt_at = swn[0] + 3;
    for (int k = 0; k < 5; k++) begin
      send(0, 1'b0, 8'h30 + 8'(k));
      wait_idle(0);
      check($sformatf("rb_flag%0d", k), {63'd0, rbe[0]}, 64'((RB == 1 && k >= 2) ? 1 : 0));
    end
    #2 reset_n = 1'b0;
    #1 check("rb_reset", {63'd0, rbe[0]}, 64'd0);
    @(negedge clk); @(posedge clk); #3 reset_n = 1'b1;
    corrupt_at = -1;
    tick();

    // write_count wrap: preset near the top, then three writes.
    force dut_b.write_count = 16'hFFFE;
    #1 release dut_b.write_count;
    m_cnt[1] = 16'hFFFE;
    send(1, 1'b1, 8'hC1); wait_idle(1);
    check("wrap_ffff", {48'd0, wc[1]}, 64'hFFFF);
    send(1, 1'b1, 8'hC2); wait_idle(1);
    check("wrap_zero", {48'd0, wc[1]}, 64'h0);
    send(1, 1'b1, 8'hC3); wait_idle(1);
    check("wrap_one", {48'd0, wc[1]}, 64'h1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pio_out_arbiter.md
# pio_out_arbiter

Round-robin arbiter and write sequencer that shares one 8-bit PIO output register slave between two byte-stream requesters. It sits between two internal producers and the Avalon-MM slave port of the PIO output register, issuing single-cycle writes to address 0 and enforcing a programmable hold interval so each value stays stable on the PIO `out_port` before it can be overwritten. An optional readback stage verifies every write.

## Interface
Parameters:
- `HOLD_CYCLES`, default 4: idle cycles inserted after each write before the next grant; legal range 0..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle.
- `req1_valid`, `req1_data`, `req1_ready`: same as requester 0.
- `pio_address`  out  2  slave address; always 0.
- `pio_chipselect`  out  1  slave chip select.
- `pio_write_n`  out  1  slave write strobe, active-low.
- `pio_writedata`  out  32  `{24'b0, byte}`.
- `pio_readdata`  in  32  slave read data; combinational from the slave register.
- `busy`  out  1  high in any state other than IDLE.
- `last_grant`  out  1  index of the most recently granted requester.
- `write_count`  out  16  number of completed writes; wraps 0xFFFF→0.
- `rb_error`  out  1  sticky readback mismatch flag.

## Operation
- FSM states: IDLE, WRITE, READ (only with the macro), HOLD.
- IDLE: `ready` is combinational and goes to at most one requester. If only one requester is valid, it gets the grant. If both are valid, the requester that is not `last_grant` gets it. A transfer is `valid && ready`. On a transfer, the byte is latched, `last_grant` updates, and the FSM goes to WRITE.
- A requester must hold `valid` and `data` stable until it sees `ready`. `ready` is 0 in every state except IDLE.
- WRITE, one cycle: `pio_chipselect`=1, `pio_write_n`=0, `pio_writedata`={24'b0, latched byte}. `write_count` increments at the end of the cycle. Next state is READ if the macro is on; otherwise HOLD, or IDLE when `HOLD_CYCLES`=0.
- READ, one cycle: `pio_chipselect`=1, `pio_write_n`=1. `pio_readdata[7:0]` is compared with the latched byte. A mismatch sets `rb_error`. Next state is HOLD, or IDLE when `HOLD_CYCLES`=0.
- HOLD: an 8-bit down-counter is loaded with `HOLD_CYCLES`-1 on entry. The FSM leaves HOLD for IDLE in the cycle the counter reads 0. HOLD therefore lasts exactly `HOLD_CYCLES` cycles.
- Outside WRITE and READ: `pio_chipselect`=0, `pio_write_n`=1. `pio_writedata` holds the last latched byte.
- Reset values, asserted asynchronously:
  - state IDLE
  - `pio_chipselect`=0, `pio_write_n`=1, `pio_address`=0, `pio_writedata`=0
  - `busy`=0, `last_grant`=1 (requester 0 wins the first contention)
  - `write_count`=0, `rb_error`=0, hold counter 0
- Reset during WRITE, READ or HOLD aborts immediately. The interrupted byte is lost and does not count. There is no partial bus cycle after release.

## Timing
- Accept at cycle T → WRITE strobe at T+1 → slave `out_port` shows the new byte from T+2.
- Earliest next accept:
  - without the macro: T+2+`HOLD_CYCLES`
  - with the macro: T+3+`HOLD_CYCLES`
- With `HOLD_CYCLES`=0 and no macro, there is one byte every 2 cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1…
- `busy` is registered from the state and rises in T+1.

## Configuration
- `PIO_ARB_READBACK_EN` defined: the READ state is present, `rb_error` is live, and each transfer costs 1 extra cycle.
- Not defined: READ is never entered, `rb_error` is tied to 0, and `pio_readdata` is ignored.

## Test plan
- Reset, then `req0_valid`=1 with 0xA5 at T → `req0_ready`=1 at T, one write of 0x000000A5 at T+1, `write_count`=1, `busy` back to 0 at T+6 (`HOLD_CYCLES`=4, no macro).
- Both requesters continuously valid (0x11, 0x22), 4 grants → write order 0x11, 0x22, 0x11, 0x22; accepts spaced 6 cycles apart.
- `HOLD_CYCLES`=0, req1 streaming 0x00..0x0F → 16 writes on every other cycle; `last_grant` stays 1.
- Macro on, slave model corrupts readback bit 0 on the third write → `rb_error` rises after that READ cycle and stays 1 through further clean writes until `reset_n`=0.
- `reset_n` pulsed low during HOLD → all outputs return to reset values asynchronously; `write_count`=0; after release, req0 wins the first contention.
- 65536 writes → `write_count` wraps to 0 and the next write reads 1.
